// File: rtl/serial_id_reader_if.sv
// Pin bundle of serial_id_reader: the reader drives the master side, the
// parent (primitive pins plus system-side status) sits on the slave side.
interface serial_id_reader_if #(
    parameter int ID_WIDTH = 57
);
    logic                start;
    logic                sdi;
    logic                sclk;
    logic                load;
    logic                shift;
    logic                sdo;
    logic [ID_WIDTH-1:0] id;
    logic                ready;
    logic                busy;
    logic                mismatch;

    modport master (
        input  start, sdi,
        output sclk, load, shift, sdo, id, ready, busy, mismatch
    );

    modport slave (
        output start, sdi,
        input  sclk, load, shift, sdo, id, ready, busy, mismatch
    );
endinterface

// File: rtl/serial_id_reader.sv
// Bit-serial device-ID reader: LOAD/SHIFT/SCLK sequencing, auto-read after reset, re-read on start.
// Optional macro SERIAL_ID_DOUBLE_READ_EN: read twice, compare, retry up to MAX_RETRY, flag mismatch.
module serial_id_reader #(
    parameter int   ID_WIDTH  = 57,
    parameter int   DIV       = 16,
    parameter logic SHIFT_IN  = 1'b1,
    parameter int   MAX_RETRY = 3
) (
    input  logic               clk_48,
    input  logic               rst_n,
    serial_id_reader_if.master bus
);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CNT_W = $clog2(ID_WIDTH + 1);
    localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(ID_WIDTH - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    if (ID_WIDTH < 2 || DIV < 1 || MAX_RETRY < 1) begin : g_bad_params
        $error("serial_id_reader: ID_WIDTH>=2, DIV>=1 and MAX_RETRY>=1 are required");
    end

    logic [1:0]          state_r;
    logic [DIV_W-1:0]    div_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [ID_WIDTH-2:0] sr_r;
    logic [ID_WIDTH-1:0] id_r;
    logic                sclk_r;
    logic                load_r;
    logic                shift_r;
    logic                ready_r;
    logic                busy_r;
    logic                tick_s;
    logic                restart_s;
    logic                last_s;
    logic [ID_WIDTH-1:0] capture_s;

`ifdef SERIAL_ID_DOUBLE_READ_EN
    localparam int RTY_W = $clog2(MAX_RETRY + 1);
    localparam logic [RTY_W-1:0] RTY_LAST = RTY_W'(MAX_RETRY - 1);

    logic [ID_WIDTH-1:0] first_r;
    logic                pass_r;
    logic [RTY_W-1:0]    retry_r;
    logic                mismatch_r;
`endif

    assign tick_s    = busy_r & (div_r == {DIV_W{1'b0}});
    assign restart_s = (state_r == ST_DONE) & bus.start;
    // cnt_r counts samples already taken, so the sample in flight is the last one here
    assign last_s    = (cnt_r == CNT_LAST);
    assign capture_s = {sr_r, bus.sdi};

    // SCLK half-period divider; runs only while a read is in progress
    always_ff @(posedge clk_48 or negedge rst_n) begin
        if (!rst_n) begin
            div_r <= DIV_RELOAD;
        end else if (restart_s || tick_s) begin
            div_r <= DIV_RELOAD;
        end else if (busy_r) begin
            div_r <= div_r - 1'b1;
        end
    end

    // Read sequencer: IDLE -> LOAD -> SHIFT -> DONE, one step per divider tick
    always_ff @(posedge clk_48 or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            sr_r       <= {(ID_WIDTH-1){1'b0}};
            id_r       <= {ID_WIDTH{1'b0}};
            sclk_r     <= 1'b0;
            load_r     <= 1'b0;
            shift_r    <= 1'b0;
            ready_r    <= 1'b0;
            busy_r     <= 1'b1;
`ifdef SERIAL_ID_DOUBLE_READ_EN
            first_r    <= {ID_WIDTH{1'b0}};
            pass_r     <= 1'b0;
            retry_r    <= {RTY_W{1'b0}};
            mismatch_r <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (tick_s) begin
                        sclk_r <= ~sclk_r;
                        if (sclk_r) begin
                            load_r  <= 1'b1;
                            state_r <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (tick_s) begin
                        sclk_r <= ~sclk_r;
                        if (sclk_r) begin
                            load_r  <= 1'b0;
                            shift_r <= 1'b1;
                            state_r <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (tick_s && sclk_r) begin
                        sclk_r  <= 1'b0;
                        shift_r <= ~last_s;
                    end else if (tick_s && !last_s) begin
                        sr_r   <= capture_s[ID_WIDTH-2:0];
                        cnt_r  <= cnt_r + 1'b1;
                        sclk_r <= 1'b1;
                    end else if (tick_s) begin
                        // final sample: sclk deliberately not raised, primitive must not shift
                        cnt_r <= {CNT_W{1'b0}};
`ifdef SERIAL_ID_DOUBLE_READ_EN
                        if (!pass_r) begin
                            first_r <= capture_s;
                            pass_r  <= 1'b1;
                            state_r <= ST_IDLE;
                        end else if ((capture_s == first_r) || (retry_r == RTY_LAST)) begin
                            pass_r     <= 1'b0;
                            id_r       <= capture_s;
                            mismatch_r <= (capture_s != first_r);
                            ready_r    <= 1'b1;
                            busy_r     <= 1'b0;
                            state_r    <= ST_DONE;
                        end else begin
                            pass_r  <= 1'b0;
                            retry_r <= retry_r + 1'b1;
                            state_r <= ST_IDLE;
                        end
`else
                        id_r    <= capture_s;
                        ready_r <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= ST_DONE;
`endif
                    end
                end
                ST_DONE: begin
                    if (bus.start) begin
                        ready_r    <= 1'b0;
                        busy_r     <= 1'b1;
                        cnt_r      <= {CNT_W{1'b0}};
                        state_r    <= ST_IDLE;
`ifdef SERIAL_ID_DOUBLE_READ_EN
                        pass_r     <= 1'b0;
                        retry_r    <= {RTY_W{1'b0}};
                        mismatch_r <= 1'b0;
`endif
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.sclk  = sclk_r;
    assign bus.load  = load_r;
    assign bus.shift = shift_r;
    assign bus.sdo   = SHIFT_IN;
    assign bus.id    = id_r;
    assign bus.ready = ready_r;
    assign bus.busy  = busy_r;
`ifdef SERIAL_ID_DOUBLE_READ_EN
    assign bus.mismatch = mismatch_r;
`else
    assign bus.mismatch = 1'b0;
`endif
endmodule

// File: tb/tb_serial_id_reader.sv
// Self-checking bench for serial_id_reader: primitive model, timeline reference model,
// per-cycle compare process, directed and randomized reads.
module tb_serial_id_reader;
    localparam int W         = 8;
    localparam int DIV       = 2;
    localparam int MAX_RETRY = 3;
    localparam int P_T       = 2 * W + 3;
`ifdef SERIAL_ID_DOUBLE_READ_EN
    localparam int PASSES = 2;
`else
    localparam int PASSES = 1;
`endif
    localparam int READ_LAT = 38 * PASSES;

    logic clk_48 = 1'b0;
    logic rst_n  = 1'b0;

    serial_id_reader_if #(.ID_WIDTH(W)) bus ();

    serial_id_reader #(
        .ID_WIDTH  (W),
        .DIV       (DIV),
        .SHIFT_IN  (1'b1),
        .MAX_RETRY (MAX_RETRY)
    ) dut (
        .clk_48 (clk_48),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    always #5 clk_48 = ~clk_48;

    // Identity primitive: parallel load on a rise with load=1, shift on a rise with shift=1
    logic [W-1:0] prim_sr  = 8'h00;
    logic [W-1:0] word     = 8'hA5;
    bit           alt_mode = 1'b0;
    int           loads    = 0;
    int           rise_load  = 0;
    int           rise_shift = 0;
    int           overlap    = 0;

    function automatic logic [W-1:0] pval(input int n);
        if (alt_mode) return (n % 2 == 0) ? 8'h11 : 8'h22;
        else          return word;
    endfunction

    assign bus.sdi = prim_sr[W-1];

    always @(posedge bus.sclk) begin
        if (bus.load) begin
            prim_sr <= pval(loads);
            loads   <= loads + 1;
            rise_load++;
        end else if (bus.shift) begin
            prim_sr <= prim_sr << 1;
            rise_shift++;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, required %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: a read is a timeline of m_len edges; outputs follow from the tick index
    bit           m_active;
    bit           m_ready;
    bit           m_mis;
    bit           m_pmis;
    int           m_t;
    int           m_len;
    int           k;
    logic [W-1:0] m_id;
    logic [W-1:0] m_pid;

    task automatic predict();
        int p;
        int passes;
`ifdef SERIAL_ID_DOUBLE_READ_EN
        logic [W-1:0] a;
        logic [W-1:0] b;
        bit           settled;
`endif
        p = loads;
`ifdef SERIAL_ID_DOUBLE_READ_EN
        passes  = 0;
        settled = 1'b0;
        for (int r = 0; r < MAX_RETRY; r++) begin
            if (!settled) begin
                a       = pval(p);
                b       = pval(p + 1);
                p       = p + 2;
                passes  = passes + 2;
                m_pid   = b;
                m_pmis  = (a != b);
                settled = (a == b);
            end
        end
`else
        passes = 1;
        m_pid  = pval(p);
        m_pmis = 1'b0;
`endif
        m_len = passes * P_T * DIV;
    endtask

    always begin
        @(posedge clk_48);
        if (!rst_n) begin
            m_active = 1'b1;
            m_t      = 0;
            m_ready  = 1'b0;
            m_id     = 8'h00;
            m_mis    = 1'b0;
        end else if (m_active) begin
            if (m_t == 0) predict();
            m_t++;
            if (m_t == m_len) begin
                m_active = 1'b0;
                m_ready  = 1'b1;
                m_id     = m_pid;
                m_mis    = m_pmis;
            end
        end else if (bus.start) begin
            m_active = 1'b1;
            m_t      = 0;
            m_ready  = 1'b0;
            m_mis    = 1'b0;
        end
        #1;
        k = m_active ? ((m_t / DIV) % P_T) : 0;
        check("sclk",     bus.sclk,     (k % 2 == 1));
        check("load",     bus.load,     (k == 2 || k == 3));
        check("shift",    bus.shift,    (k >= 4 && k <= 2 * W + 1));
        check("sdo",      bus.sdo,      1'b1);
        check("busy",     bus.busy,     m_active);
        check("ready",    bus.ready,    m_ready);
        check("id",       bus.id,       m_id);
        check("mismatch", bus.mismatch, m_mis);
        if (bus.load && bus.shift) overlap++;
    end

    // Called on a negedge; counts edges until ready, optionally pulsing start on edge mid_at+1
    task automatic wait_ready(input int mid_at, output int edges);
        bit done;
        done  = 1'b0;
        edges = 0;
        while (!done) begin
            bus.start = (edges == mid_at);
            @(posedge clk_48);
            #1;
            bus.start = 1'b0;
            edges++;
            if (bus.ready) begin
                done = 1'b1;
            end else if (edges > 2000) begin
                n_checks++;
                n_fail++;
                $display("FAIL ready_timeout: got no ready after %0d edges, required ready", edges);
                done = 1'b1;
            end else begin
                @(negedge clk_48);
            end
        end
    endtask

    task automatic pulse_start(input logic [W-1:0] old_id);
        @(negedge clk_48);
        bus.start = 1'b1;
        @(posedge clk_48);
        #1;
        bus.start = 1'b0;
        check("start_ready_drop", bus.ready, 1'b0);
        check("start_id_hold",    bus.id,    old_id);
        check("start_busy",       bus.busy,  1'b1);
        @(negedge clk_48);
    endtask

    int edges;
    int action;

    initial begin
        bus.start = 1'b0;
        repeat (3) @(negedge clk_48);
        rst_n = 1'b1;

        // automatic read after reset
        wait_ready(-1, edges);
        check("first_latency", edges,      READ_LAT);
        check("first_id",      bus.id,     8'hA5);
        check("first_busy",    bus.busy,   1'b0);
        check("load_rises",    rise_load,  1 * PASSES);
        check("shift_rises",   rise_shift, 7 * PASSES);
        check("overlap",       overlap,    0);
        repeat (10) @(posedge clk_48);
        #1;
        check("done_sclk_frozen", bus.sclk, 1'b0);

        // re-read with new value, extra start mid-read ignored
        word = 8'h3C;
        pulse_start(8'hA5);
        wait_ready(10, edges);
        check("reread_latency", edges,  READ_LAT);
        check("reread_id",      bus.id, 8'h3C);

        // start coincident with the completing capture is ignored
        word = 8'h96;
        pulse_start(8'h3C);
        wait_ready(READ_LAT - 1, edges);
        check("coincident_latency", edges, READ_LAT);
        repeat (4) @(posedge clk_48);
        #1;
        check("coincident_ready", bus.ready, 1'b1);
        check("coincident_busy",  bus.busy,  1'b0);

        // reset during SHIFT with four samples taken
        pulse_start(8'h96);
        repeat (23) @(posedge clk_48);
        @(negedge clk_48);
        rst_n = 1'b0;
        #1;
        check("rst_busy",  bus.busy,  1'b1);
        check("rst_ready", bus.ready, 1'b0);
        check("rst_sclk",  bus.sclk,  1'b0);
        check("rst_shift", bus.shift, 1'b0);
        check("rst_id",    bus.id,    8'h00);
        word = 8'h5A;
        repeat (2) @(negedge clk_48);
        rst_n = 1'b1;
        wait_ready(-1, edges);
        check("post_rst_latency", edges,  READ_LAT);
        check("post_rst_id",      bus.id, 8'h5A);

        // randomized reads, stray starts and aborts
        for (int i = 0; i < 16; i++) begin
            action = $urandom_range(0, 3);
            word   = W'($urandom);
            if (action == 2) begin
                pulse_start(m_id);
                repeat ($urandom_range(1, READ_LAT - 2)) @(posedge clk_48);
                @(negedge clk_48);
                rst_n = 1'b0;
                repeat (2) @(negedge clk_48);
                rst_n = 1'b1;
                wait_ready(-1, edges);
            end else begin
                if (action == 3) repeat ($urandom_range(1, 20)) @(negedge clk_48);
                pulse_start(m_id);
                wait_ready((action == 1) ? int'($urandom_range(0, READ_LAT - 1)) : -1, edges);
            end
            check("rand_latency", edges,  READ_LAT);
            check("rand_id",      bus.id, word);
        end

`ifdef SERIAL_ID_DOUBLE_READ_EN
        // alternating primitive: three failed compares over six passes
        alt_mode = 1'b1;
        pulse_start(m_id);
        wait_ready(-1, edges);
        check("alt_latency",  edges,        228);
        check("alt_mismatch", bus.mismatch, 1'b1);
        alt_mode = 1'b0;
        word     = 8'h77;
        pulse_start(m_id);
        wait_ready(-1, edges);
        check("stable_latency",  edges,        76);
        check("stable_mismatch", bus.mismatch, 1'b0);
        check("stable_id",       bus.id,       8'h77);
`endif

        check("overlap_total", overlap, 0);
        repeat (5) @(posedge clk_48);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
